// File: rtl/lzc_sched.sv
// Round-robin arbiter that time-shares one external leading-zero counter among NREQ
// requesters: grant, stream the operand MSB beat first, await the count, return it.
module lzc_sched #(
  parameter int WIDTH   = 8,
  parameter int WORD    = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  localparam int OPW    = WIDTH * WORD,
  localparam int IDW    = (NREQ > 2) ? $clog2(NREQ) : 1,
  localparam int ZW     = $clog2(OPW) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_data,
  input  logic [NREQ-1:0]     req_mode,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [ZW-1:0]       rsp_zeros,
  output logic                rsp_err,
  output logic [WIDTH-1:0]    lzc_data,
  output logic                lzc_Ivalid,
  output logic                lzc_mode,
  input  logic [ZW-1:0]       lzc_zeros,
  input  logic                lzc_Ovalid
);

  localparam int BW = $clog2(WORD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SEND, S_WAIT, S_RESP} state_t;

  state_t          state, nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gid;
  logic            gnt_any;
  logic [NREQ-1:0] gnt;
  logic [BW-1:0]   beat_cnt;
  logic [TW-1:0]   wait_cnt;
  logic [OPW-1:0]  op_p0;
  logic [IDW-1:0]  id_p0;

  // Search starts one past the last winner and wraps, so the last winner ranks lowest.
  always_comb begin
    int idx;
    idx     = 0;
    gid     = '0;
    gnt_any = 1'b0;
    gnt     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gid     = IDW'(idx);
      end
    end
    if (state == S_IDLE && gnt_any) gnt[gid] = 1'b1;
  end

  assign req_ready = rst ? '0 : gnt;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (gnt_any) nxt = S_SETUP;
      S_SETUP: nxt = S_SEND;
      S_SEND:  if (beat_cnt == BW'(WORD)) nxt = S_WAIT;
      S_WAIT:  if (lzc_Ovalid || wait_cnt == TW'(TIMEOUT - 1)) nxt = S_RESP;
      S_RESP:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // p0: operand and id captured at grant; operand shifts left one beat per emitted beat
  always_ff @(posedge clk) begin
    if (state == S_IDLE && gnt_any) begin
      op_p0 <= req_data[int'(gid)*OPW +: OPW];
      id_p0 <= gid;
    end else if (nxt == S_SEND) begin
      op_p0 <= op_p0 << WIDTH;
    end
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= IDW'(NREQ - 1);
      beat_cnt   <= '0;
      wait_cnt   <= '0;
      lzc_data   <= '0;
      lzc_Ivalid <= 1'b0;
      lzc_mode   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_zeros  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= nxt;
      lzc_Ivalid <= (nxt == S_SEND);
      lzc_data   <= (nxt == S_SEND) ? op_p0[OPW-1 -: WIDTH] : '0;
      rsp_valid  <= (nxt == S_RESP);
      rsp_id     <= (nxt == S_RESP) ? id_p0 : '0;
      rsp_err    <= (nxt == S_RESP) && !lzc_Ovalid;
      rsp_zeros  <= (nxt == S_RESP && lzc_Ovalid) ? lzc_zeros : '0;
      if (nxt == S_SEND) beat_cnt <= beat_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            ptr      <= gid;
            lzc_mode <= req_mode[gid];
            beat_cnt <= '0;
          end
        end
        S_SEND:  wait_cnt <= '0;
        S_WAIT:  wait_cnt <= wait_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lzc_sched.sv
// Bench for lzc_sched: stub lzc with programmable latency, timing-rule reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_lzc_sched;
  localparam int WIDTH   = 8;
  localparam int WORD    = 4;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int OPW     = WIDTH * WORD;
  localparam int IDW     = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int ZW      = $clog2(OPW) + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready, req_mode;
  logic [NREQ*OPW-1:0] req_data;
  logic                rsp_valid, rsp_err, lzc_Ivalid, lzc_mode;
  logic [IDW-1:0]      rsp_id;
  logic [ZW-1:0]       rsp_zeros;
  logic [WIDTH-1:0]    lzc_data;
  logic [ZW-1:0]       lzc_zeros = '0;
  logic                lzc_Ovalid = 1'b0;

  logic [OPW-1:0]  rd [NREQ];
  logic [NREQ-1:0] rv = '0, rm = '0;
  logic [NREQ-1:0] acc = '0;

  lzc_sched #(.WIDTH(WIDTH), .WORD(WORD), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_zeros(rsp_zeros), .rsp_err(rsp_err),
    .lzc_data(lzc_data), .lzc_Ivalid(lzc_Ivalid), .lzc_mode(lzc_mode),
    .lzc_zeros(lzc_zeros), .lzc_Ovalid(lzc_Ovalid)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*OPW +: OPW] = rd[i];
  end
  assign req_valid = rv;
  assign req_mode  = rm;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) acc <= req_valid & req_ready;

  int nvec = 0, nmis = 0;
  function automatic void chk(string nm, longint act, longint exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int clz(logic [OPW-1:0] v);
    for (int i = OPW - 1; i >= 0; i--) if (v[i]) return OPW - 1 - i;
    return OPW;
  endfunction

  // Stub latency (cycles from WAIT entry to Ovalid); -1 means never answer.
  int lat_force = 3;
  int lat_tab [256];
  function automatic int lat_of(int n);
    return (lat_force != -2) ? lat_force : lat_tab[n % 256];
  endfunction

  bit             busy = 0;
  int             t_g, m_d, m_r, m_id, m_ptr = NREQ - 1, txn_n = 0;
  logic [OPW-1:0] m_op;
  logic           m_md, mode_exp = 1'b0;
  int             glog [$];
  int             sb_beats = 0, sched = -1, quiet_until = -1, sb_zeros = 0, stub_E = 0;
  logic [OPW-1:0] sbuf = '0;
  int             beat_log [$];
  int             rdy_cnt [NREQ];
  int             rsp_cnt = 0;

  // Reference model: expected outputs follow from grant time, beat count and stub latency.
  initial begin : model
    logic            e_iv, e_rv, e_er, found;
    logic [WIDTH-1:0] e_data;
    logic [NREQ-1:0] e_rdy;
    logic [OPW-1:0]  tmp;
    int              e_id, e_z, k, g, j, d;
    for (int i = 0; i < NREQ; i++) rdy_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_ready", req_ready, 0);
        chk("rst_lzc_Ivalid", lzc_Ivalid, 0);
        chk("rst_lzc_data", lzc_data, 0);
        chk("rst_lzc_mode", lzc_mode, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_zeros", rsp_zeros, 0);
        chk("rst_rsp_err", rsp_err, 0);
        busy = 0; m_ptr = NREQ - 1; mode_exp = 1'b0;
        sb_beats = 0; sched = -1; quiet_until = -1;
      end else begin
        e_iv = 0; e_data = '0; e_rv = 0; e_id = 0; e_z = 0; e_er = 0;
        if (busy) begin
          if (cyc == t_g + 1) mode_exp = m_md;
          k = cyc - t_g - 2;
          if (k >= 0 && k < WORD) begin
            e_iv = 1; tmp = m_op << (k * WIDTH); e_data = tmp[OPW-1 -: WIDTH];
          end
          if (cyc == m_r) begin
            e_rv = 1; e_id = m_id;
            if (m_d >= 0 && m_d < TIMEOUT) e_z = clz(m_op); else e_er = 1;
          end
        end
        chk("lzc_Ivalid", lzc_Ivalid, e_iv);
        chk("lzc_data", lzc_data, e_data);
        chk("lzc_mode", lzc_mode, mode_exp);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_id", rsp_id, e_id);
        chk("rsp_zeros", rsp_zeros, e_z);
        chk("rsp_err", rsp_err, e_er);
        e_rdy = '0; found = 0; g = 0;
        if (!busy) begin
          for (int i = 1; i <= NREQ; i++) begin
            j = (m_ptr + i) % NREQ;
            if (!found && rv[j]) begin found = 1; g = j; e_rdy[j] = 1'b1; end
          end
        end
        chk("req_ready", req_ready, e_rdy);
        if (busy && cyc == m_r) busy = 0;
        else if (!busy && found) begin
          busy = 1; t_g = cyc; m_op = rd[g]; m_md = rm[g]; m_id = g; m_ptr = g;
          m_d = lat_of(txn_n); txn_n++; glog.push_back(g);
          m_r = (m_d >= 0 && m_d < TIMEOUT) ? t_g + 2 + WORD + m_d + 1 : t_g + 2 + WORD + TIMEOUT;
        end
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) rdy_cnt[i]++;
        if (rsp_valid) rsp_cnt++;
        // stub lzc: collect beats and schedule the answer
        if (lzc_Ivalid) begin
          sbuf = {sbuf[OPW-WIDTH-1:0], lzc_data};
          beat_log.push_back(int'(lzc_data));
          sb_beats++;
          if (sb_beats == WORD) begin
            sb_beats = 0; d = lat_of(txn_n - 1); stub_E = cyc + 1;
            sched = (d >= 0) ? stub_E + d : -1;
            quiet_until = stub_E + ((d >= 0) ? d : TIMEOUT);
            sb_zeros = clz(sbuf);
          end
        end
      end
    end
  end

  // Stub drive: real answer on schedule, otherwise occasional stray Ovalid outside WAIT.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (cyc == sched) begin
        lzc_Ovalid = 1'b1; lzc_zeros = ZW'(sb_zeros);
      end else if (cyc > quiet_until && $urandom_range(0, 7) == 0) begin
        lzc_Ovalid = 1'b1; lzc_zeros = ZW'($urandom_range(0, OPW));
      end else begin
        lzc_Ovalid = 1'b0; lzc_zeros = ZW'($urandom);
      end
    end
  end

  task automatic do_req(input int i, input logic [OPW-1:0] d, input logic m);
    int n = 0;
    bit ok = 0;
    @(posedge clk); #1;
    rv[i] = 1'b1; rd[i] = d; rm[i] = m;
    while (!ok && n < 500) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1;
      n++;
    end
    chk("grant_wait", ok, 1);
    @(posedge clk); #1;
    rv[i] = 1'b0;
  endtask

  task automatic wait_rsp(output int id, output int z, output int e, output int c);
    int n = 0;
    bit ok = 0;
    id = -1; z = -1; e = -1; c = -1;
    while (!ok && n < 300) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; id = rsp_id; z = rsp_zeros; e = rsp_err; c = cyc; end
      n++;
    end
    chk("rsp_wait", ok, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    bit ok = 0;
    while (!ok && n < 2000) begin
      @(negedge clk);
      if (!busy && rv == '0) ok = 1;
      n++;
    end
    chk("idle_wait", ok, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
  endtask

  function automatic logic [OPW-1:0] rnd_op();
    logic [OPW-1:0] x;
    x = OPW'($urandom);
    return x >> $urandom_range(0, OPW);
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int id, z, e, c, n;
    int exp3 [5] = '{0, 1, 2, 3, 0};
    bit ok;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) rd[i] = '0;
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 15))
        0:       lat_tab[i] = -1;
        1:       lat_tab[i] = TIMEOUT - 1;
        2:       lat_tab[i] = TIMEOUT;
        default: lat_tab[i] = $urandom_range(0, 6);
      endcase
    end
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;

    // basic operand, beat order, single-cycle ready
    beat_log.delete(); rdy_cnt[0] = 0;
    do_req(0, 32'h0FFF_FFFF, 1'b0);
    wait_rsp(id, z, e, c);
    chk("t1_id", id, 0); chk("t1_zeros", z, 4); chk("t1_err", e, 0);
    chk("t1_ready_cycles", rdy_cnt[0], 1);
    chk("t1_beats", beat_log.size(), 4);
    chk("t1_beat0", beat_log[0], 8'h0F); chk("t1_beat1", beat_log[1], 8'hFF);
    chk("t1_beat3", beat_log[3], 8'hFF);

    // all-zero operand with mode=1
    do_req(2, 32'h0000_0000, 1'b1);
    @(negedge clk);
    chk("t2_mode_setup", lzc_mode, 1);
    wait_rsp(id, z, e, c);
    chk("t2_id", id, 2); chk("t2_zeros", z, 32); chk("t2_err", e, 0);
    chk("t2_mode_hold", lzc_mode, 1);

    // all requesters pending after reset
    do_reset(); glog.delete();
    fork
      begin do_req(0, rnd_op(), 1'b0); do_req(0, rnd_op(), 1'b1); end
      do_req(1, rnd_op(), 1'b1);
      do_req(2, rnd_op(), 1'b0);
      do_req(3, rnd_op(), 1'b1);
    join
    wait_idle();
    chk("t3_grants", glog.size(), 5);
    for (int i = 0; i < 5; i++) chk("t3_grant_order", glog[i], exp3[i]);

    // pointer at 0, requesters 1 and 3 contend
    do_reset();
    do_req(0, rnd_op(), 1'b0);
    wait_idle(); glog.delete();
    fork
      do_req(1, rnd_op(), 1'b0);
      do_req(3, rnd_op(), 1'b0);
    join
    wait_idle();
    chk("t4_first", glog[0], 1); chk("t4_second", glog[1], 3);

    // timeout and the Ovalid-versus-timeout boundary
    do_reset(); lat_force = -1;
    do_req(1, 32'h00FF_0000, 1'b0);
    wait_rsp(id, z, e, c);
    chk("t5_id", id, 1); chk("t5_err", e, 1); chk("t5_zeros", z, 0);
    chk("t5_latency", c - stub_E, TIMEOUT);
    lat_force = TIMEOUT - 1;
    do_req(2, 32'h0000_0100, 1'b0);
    wait_rsp(id, z, e, c);
    chk("t5b_err", e, 0); chk("t5b_zeros", z, 23); chk("t5b_latency", c - stub_E, TIMEOUT);
    lat_force = TIMEOUT;
    do_req(3, 32'h0000_0100, 1'b0);
    wait_rsp(id, z, e, c);
    chk("t5c_err", e, 1); chk("t5c_zeros", z, 0);
    lat_force = 0;
    do_req(0, 32'h8000_0000, 1'b0);
    wait_rsp(id, z, e, c);
    chk("t5d_zeros", z, 0); chk("t5d_err", e, 0); chk("t5d_latency", c - stub_E, 1);

    // reset during beat 2 of SEND
    lat_force = 3;
    do_reset();
    do_req(0, 32'hDEAD_BEEF, 1'b0);
    ok = 0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (sb_beats == 2) ok = 1;
      n++;
    end
    chk("t6_reach_beat2", ok, 1);
    @(posedge clk); #1;
    chk("t6_ivalid_before", lzc_Ivalid, 1);
    rsp_cnt = 0; rst = 1'b1;
    #1;
    chk("t6_ivalid_async", lzc_Ivalid, 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_no_rsp", rsp_cnt, 0);
    do_req(0, 32'h0001_0000, 1'b0);
    wait_rsp(id, z, e, c);
    chk("t6_id", id, 0); chk("t6_zeros", z, 15); chk("t6_err", e, 0);

    // random traffic with drops, varied latency and rare resets
    lat_force = -2;
    for (int t = 0; t < 4000; t++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 999) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (rv[i] && acc[i]) rv[i] = 1'b0;
        else if (rv[i] && $urandom_range(0, 63) == 0) rv[i] = 1'b0;
        else if (!rv[i] && $urandom_range(0, 3) == 0) begin
          rv[i] = 1'b1; rd[i] = rnd_op(); rm[i] = 1'($urandom_range(0, 1));
        end
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; rv = '0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
